// File: rtl/safe_pkg.sv
// Types and constants shared by the safe controller's code-entry blocks.
package safe_pkg;

    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        READY    = 2'd1,
        FULL     = 2'd2
    } entry_state_t;

    // Digits per code; also used by the code register and comparator.
    localparam int unsigned DIGIT_LIMIT_DEF = 4;

endpackage

// File: rtl/rise_detect.sv
// Registered rising-edge detector for a clk-synchronous strobe.
module rise_detect (
    input  logic clk,
    input  logic sys_reset,
    input  logic d,
    output logic rise
);

    logic prev_q;

    always_ff @(posedge clk) begin
        if (sys_reset) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= d;
        end
    end

    assign rise = d & ~prev_q;

endmodule

// File: rtl/entry_handler.sv
// Turns debounced key strobes into one-cycle store/increment pulses while entry
// is enabled, capping the number of accepted digits per enable window.
module entry_handler
    import safe_pkg::*;
#(
    parameter int unsigned DIGIT_LIMIT = DIGIT_LIMIT_DEF
) (
    input  logic clk,
    input  logic sys_reset,
    input  logic enable_entry,
    input  logic entry_pulse,
    output logic store_digit_pulse,
    output logic increment_counter_pulse
);

    localparam int unsigned CNT_W = (DIGIT_LIMIT == 0) ? 1 : $clog2(DIGIT_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(DIGIT_LIMIT);

    entry_state_t     state_q;
    logic [CNT_W-1:0] count_q;
    logic             pulse_q;
    logic             rise;
    logic             accept;
    logic [CNT_W-1:0] count_nxt;

    rise_detect u_rise_detect (
        .clk       (clk),
        .sys_reset (sys_reset),
        .d         (entry_pulse),
        .rise      (rise)
    );

    // DISABLED still accepts on the edge where enable is already high.
    assign accept    = enable_entry & rise & (state_q != FULL);
    assign count_nxt = (count_q == CNT_MAX) ? count_q : count_q + 1'b1;

    always_ff @(posedge clk) begin
        if (sys_reset) begin
            state_q <= DISABLED;
            count_q <= '0;
            pulse_q <= 1'b0;
        end else begin
            pulse_q <= accept;
            if (!enable_entry) begin
                state_q <= DISABLED;
                count_q <= '0;
            end else if (accept) begin
                count_q <= count_nxt;
                state_q <= (DIGIT_LIMIT != 0 && count_nxt == LIMIT) ? FULL : READY;
            end else if (state_q == DISABLED) begin
                state_q <= READY;
            end
        end
    end

    // Both strobes come from one register so they can never diverge.
    assign store_digit_pulse       = pulse_q;
    assign increment_counter_pulse = pulse_q;

endmodule

// File: tb/tb_entry_handler.sv
// Directed bench for entry_handler: limited (4) and unlimited (0) builds.
module tb_entry_handler;

    logic clk = 1'b0;
    logic sys_reset;
    logic enable_entry;
    logic enable_unl;
    logic entry_pulse;
    logic store4, incr4;
    logic store_u, incr_u;

    int n_total = 0;
    int n_bad   = 0;

    always #10 clk = ~clk;

    entry_handler #(.DIGIT_LIMIT(4)) u_dut (
        .clk                     (clk),
        .sys_reset               (sys_reset),
        .enable_entry            (enable_entry),
        .entry_pulse             (entry_pulse),
        .store_digit_pulse       (store4),
        .increment_counter_pulse (incr4)
    );

    entry_handler #(.DIGIT_LIMIT(0)) u_dut_unl (
        .clk                     (clk),
        .sys_reset               (sys_reset),
        .enable_entry            (enable_unl),
        .entry_pulse             (entry_pulse),
        .store_digit_pulse       (store_u),
        .increment_counter_pulse (incr_u)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle strobe, then 3 cycles of spacing; checks the pulse and its release.
    task automatic press(input string tag, input logic exp);
        entry_pulse = 1'b1;
        tick();
        check({tag, "_store"}, store4, exp);
        check({tag, "_incr"}, incr4, exp);
        entry_pulse = 1'b0;
        tick();
        check({tag, "_clear"}, store4 | incr4, 1'b0);
        tick();
        tick();
    endtask

    initial begin
        int pulses;
        sys_reset    = 1'b1;
        enable_entry = 1'b0;
        enable_unl   = 1'b0;
        entry_pulse  = 1'b0;
        #100;
        tick();
        check("reset_store", store4, 1'b0);
        check("reset_incr", incr4, 1'b0);
        sys_reset = 1'b0;
        tick();

        press("dis0", 1'b0);
        press("dis1", 1'b0);

        enable_entry = 1'b1;
        tick();
        press("acc0", 1'b1);
        press("acc1", 1'b1);
        press("acc2", 1'b1);
        press("acc3", 1'b1);
        press("full", 1'b0);

        enable_entry = 1'b0;
        tick();
        enable_entry = 1'b1;
        tick();
        press("reen", 1'b1);

        // Held strobe: one accept only.
        pulses = 0;
        entry_pulse = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (store4) pulses++;
        end
        entry_pulse = 1'b0;
        tick();
        check("held_count", pulses, 1);

        // Strobe already high when enable rises.
        enable_entry = 1'b0;
        tick();
        entry_pulse = 1'b1;
        tick();
        tick();
        enable_entry = 1'b1;
        tick();
        check("prehigh_a", store4, 1'b0);
        tick();
        check("prehigh_b", store4, 1'b0);
        entry_pulse = 1'b0;
        tick();
        press("after_prehigh", 1'b1);

        // Enable falls on the same edge as a rise.
        enable_entry = 1'b0;
        entry_pulse  = 1'b1;
        tick();
        check("en_fall_rise", store4, 1'b0);
        entry_pulse = 1'b0;
        tick();
        press("dis2", 1'b0);

        // Reset coincident with an enabled rise.
        enable_entry = 1'b1;
        tick();
        tick();
        entry_pulse = 1'b1;
        sys_reset   = 1'b1;
        tick();
        check("rst_rise", store4 | incr4, 1'b0);
        sys_reset   = 1'b0;
        entry_pulse = 1'b0;
        tick();
        check("rst_after", store4, 1'b0);
        press("post_rst0", 1'b1);
        press("post_rst1", 1'b1);
        press("post_rst2", 1'b1);
        press("post_rst3", 1'b1);
        press("post_rst_full", 1'b0);

        // Unlimited build: 20 spaced strobes, 20 pulses.
        enable_unl = 1'b1;
        tick();
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            entry_pulse = 1'b1;
            tick();
            if (store_u && incr_u) pulses++;
            entry_pulse = 1'b0;
            tick();
            if (store_u || incr_u) pulses += 100;
            tick();
        end
        check("unl_count", pulses, 20);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
